// File: rtl/mips_dmem_arbiter.sv
// Purpose : shares one single-port data memory between the core port (M0) and a DMA/debug port (M1), round-robin.
// Latency : request sampled in IDLE -> memory access next cycle -> one-cycle ack the cycle after (3 cycles per access).
// Backpressure: a requester holds req until its ack; the loser of arbitration simply waits with req held.
module mips_dmem_arbiter #(
    parameter int LOCATIONS = 256,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              RST,
    // core load/store port
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    // DMA / debug port
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    // memory side
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy
);

    // Unsigned full-width limit; any address at or above it is rejected.
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(LOCATIONS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    // rr names the master favoured on a tie (0 = M0, 1 = M1)
    logic                rr;
    // gnt names the master owning the access in flight
    logic                gnt;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic                any_req;
    logic                win;
    logic                addr_ok;

    assign any_req = m0_req | m1_req;
    assign addr_ok = (addr_q < LIMIT);

    // Pick the winner: pointer decides a tie, otherwise the sole requester.
    always_comb begin
        win = 1'b0;
        if (m0_req && m1_req) begin
            win = rr;
        end else if (m1_req) begin
            win = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state outputs; the ack path only opens in DONE.
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m0_rdata  = '0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        m1_rdata  = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // Out-of-range writes must never reach the array.
                mem_we    = we_q & addr_ok;
                state_nxt = DONE;
            end
            DONE: begin
                if (gnt) begin
                    m1_ack   = 1'b1;
                    m1_err   = err_q;
                    m1_rdata = rdata_q;
                end else begin
                    m0_ack   = 1'b1;
                    m0_err   = err_q;
                    m0_rdata = rdata_q;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winning request on leaving IDLE; later input changes are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gnt     <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && any_req) begin
            gnt     <= win;
            we_q    <= win ? m1_we    : m0_we;
            addr_q  <= win ? m1_addr  : m0_addr;
            wdata_q <= win ? m1_wdata : m0_wdata;
        end
    end

    // Capture the memory result at the end of ACCESS; writes and errors return zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state == ACCESS) begin
            err_q   <= ~addr_ok;
            rdata_q <= (addr_ok && !we_q) ? mem_rd : '0;
        end
    end

    // Hand the tie-break to the other master once an access completes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr <= 1'b0;
        end else if (state == DONE) begin
            rr <= ~gnt;
        end
    end

    // Memory address/data keep the last latched request between accesses.
    assign mem_a  = addr_q;
    assign mem_wd = wdata_q;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_mips_dmem_arbiter;

    localparam int LOC  = 256;
    localparam int NCYC = 3000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we, busy;

    logic [31:0] mem [0:LOC-1];
    logic        mem_clr;

    int tests = 0;
    int fails = 0;

    mips_dmem_arbiter #(.LOCATIONS(LOC), .DATA_W(32), .ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Behavioural single-port memory: combinational read, posedge write.
    assign mem_rd = mem[mem_a[7:0]];
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < LOC; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_a[7:0]] <= mem_wd;
        end
    end

    typedef struct packed {
        logic        busy;
        logic        mem_we;
        logic        ack0;
        logic        err0;
        logic        ack1;
        logic        err1;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } obs_t;

    typedef struct {
        bit          m;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          err;
        logic [31:0] rd;
        int          wes;
    } vec_t;

    vec_t        vecs[$];
    obs_t        e, got;
    obs_t        exp_q[$];
    logic [31:0] ref_mem [0:LOC-1];
    int          lat, wes, nack, a0, a1, drop_at, seen, bad;
    int          iss0, iss1, ackc0, ackc1;
    logic        err_o, oth, rr_m, was_busy, w, t_we, legal, drop0, drop1;
    logic [31:0] rd_o, r0, r1, t_addr, t_wd, res;
    logic [7:0]  bz, order;

    function automatic obs_t sample();
        obs_t o;
        o.busy = busy;   o.mem_we = mem_we;
        o.ack0 = m0_ack; o.err0 = m0_err; o.rd0 = m0_rdata;
        o.ack1 = m1_ack; o.err1 = m1_err; o.rd1 = m1_rdata;
        return o;
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0:       a = 32'd256 + 32'($urandom_range(0, 3));
            1:       a = $urandom;
            2:       a = 32'd255;
            default: a = 32'($urandom_range(0, 15));
        endcase
        return a;
    endfunction

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
        #1 check("reset_outputs", {sample(), mem_a, mem_wd}, '0);
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    // One access from an idle arbiter; reports ack cycle, result and write-enable count.
    task automatic do_access(input bit m, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                             output int lt, output logic er, output logic [31:0] rd,
                             output int nw, output logic other);
        lt = -1; er = 1'b0; rd = '0; nw = 0; other = 1'b0;
        @(posedge CLK); #1;
        if (m) begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wd; end
        else   begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wd; end
        for (int k = 1; k <= 8 && lt < 0; k++) begin
            @(negedge CLK);
            if (mem_we) nw++;
            if (m ? m0_ack : m1_ack) other = 1'b1;
            if (m ? m1_ack : m0_ack) begin
                lt = k;
                er = m ? m1_err : m0_err;
                rd = m ? m1_rdata : m0_rdata;
            end
        end
        @(posedge CLK); #1;
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    initial begin
        RST = 1'b1; mem_clr = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        #2 check("reset_state", {sample(), mem_a, mem_wd}, '0);
        repeat (2) @(posedge CLK);
        #1 mem_clr = 1'b0; RST = 1'b0;

        // ---------------- directed single-access vectors ----------------
        vecs.push_back('{0, 1, 32'd5,          32'hDEADBEEF, 0, 32'h0,        1});
        vecs.push_back('{0, 0, 32'd5,          32'h0,        0, 32'hDEADBEEF, 0});
        vecs.push_back('{1, 1, 32'd256,        32'hAAAA5555, 1, 32'h0,        0});
        vecs.push_back('{0, 0, 32'd0,          32'h0,        0, 32'h0,        0});
        vecs.push_back('{1, 1, 32'd255,        32'h12345678, 0, 32'h0,        1});
        vecs.push_back('{1, 0, 32'd255,        32'h0,        0, 32'h12345678, 0});
        vecs.push_back('{0, 1, 32'd0,          32'h77777777, 0, 32'h0,        1});
        vecs.push_back('{1, 0, 32'd256,        32'h0,        1, 32'h0,        0});
        vecs.push_back('{0, 0, 32'd0,          32'h0,        0, 32'h77777777, 0});
        vecs.push_back('{1, 1, 32'hFFFFFFFF,   32'h00001111, 1, 32'h0,        0});
        vecs.push_back('{0, 1, 32'h80000005,   32'h00002222, 1, 32'h0,        0});
        vecs.push_back('{1, 0, 32'd5,          32'h0,        0, 32'hDEADBEEF, 0});
        foreach (vecs[i]) begin
            do_access(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wd, lat, err_o, rd_o, wes, oth);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_err_rdata", i), {err_o, rd_o}, {vecs[i].err, vecs[i].rd});
            check($sformatf("vec%0d_we_cycles", i), wes, vecs[i].wes);
            check($sformatf("vec%0d_other_ack", i), oth, 0);
        end

        // ---------------- simultaneous reads after reset ----------------
        do_reset();
        @(posedge CLK); #1;
        m0_req = 1; m0_we = 0; m0_addr = 5;
        m1_req = 1; m1_we = 0; m1_addr = 255;
        a0 = -1; a1 = -1; bz = '0; r0 = '0; r1 = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            bz[k-1] = busy;
            if (m0_ack && a0 < 0) begin a0 = k; r0 = m0_rdata; end
            if (m1_ack && a1 < 0) begin a1 = k; r1 = m1_rdata; end
            @(posedge CLK); #1;
            if (a0 == k) m0_req = 0;
            if (a1 == k) m1_req = 0;
        end
        check("tie_m0_ack_cycle", a0, 3);
        check("tie_m1_ack_cycle", a1, 6);
        check("tie_m0_rdata", r0, 32'hDEADBEEF);
        check("tie_m1_rdata", r1, 32'h12345678);
        check("tie_busy_pattern", bz, 8'b0011_0110);

        // ---------------- continuous contention ----------------
        do_reset();
        @(posedge CLK); #1;
        m0_req = 1; m0_we = 0; m0_addr = 1;
        m1_req = 1; m1_we = 0; m1_addr = 2;
        nack = 0; order = '0;
        for (int k = 1; k <= 30 && nack < 6; k++) begin
            @(negedge CLK);
            if (m0_ack && nack < 8) begin order[nack] = 1'b0; nack++; end
            if (m1_ack && nack < 8) begin order[nack] = 1'b1; nack++; end
        end
        @(posedge CLK); #1;
        m0_req = 0; m1_req = 0;
        check("alt_ack_count", nack, 6);
        check("alt_grant_order", order, 8'b0010_1010);

        // ---------------- reset in the middle of an M0 write ----------------
        do_reset();
        do_access(0, 0, 32'd5, 32'h0, lat, err_o, rd_o, wes, oth);
        @(posedge CLK); #1;
        m0_req = 1; m0_we = 1; m0_addr = 32'd10; m0_wdata = 32'hCAFEF00D;
        @(negedge CLK);
        @(negedge CLK);
        check("abort_we_before_reset", mem_we, 1);
        #1 RST = 1'b1; m0_req = 1'b0;
        #1 check("abort_outputs_immediate", {sample(), mem_a, mem_wd}, '0);
        seen = 0;
        repeat (2) begin @(negedge CLK); if (m0_ack || m1_ack) seen = 1; end
        @(posedge CLK); #1 RST = 1'b0;
        repeat (3) begin @(negedge CLK); if (m0_ack || m1_ack) seen = 1; end
        check("abort_no_ack", seen, 0);
        check("abort_no_write", mem[10], 32'h0);
        @(posedge CLK); #1;
        m0_req = 1; m0_we = 0; m0_addr = 32'd10;
        m1_req = 1; m1_we = 0; m1_addr = 32'd255;
        a0 = -1;
        for (int k = 1; k <= 8 && a0 < 0; k++) begin
            @(negedge CLK);
            if (m0_ack) a0 = k;
            else if (m1_ack) a0 = 100 + k;
        end
        @(posedge CLK); #1;
        m0_req = 0; m1_req = 0;
        check("abort_rr_cleared_m0_first", a0, 3);
        do_access(0, 1, 32'd10, 32'hCAFEF00D, lat, err_o, rd_o, wes, oth);
        check("abort_retry_latency", lat, 3);
        check("abort_retry_we_cycles", wes, 1);
        do_access(1, 0, 32'd10, 32'h0, lat, err_o, rd_o, wes, oth);
        check("abort_retry_readback", {err_o, rd_o}, {1'b0, 32'hCAFEF00D});

        // ---------------- requester holds req one cycle too long ----------------
        @(posedge CLK); #1;
        m0_req = 1; m0_we = 1; m0_addr = 32'd20; m0_wdata = 32'h00000011;
        nack = 0; wes = 0; drop_at = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (mem_we) wes++;
            if (m0_ack) begin nack++; if (drop_at < 0) drop_at = k + 1; end
            @(posedge CLK); #1;
            if (k == drop_at) m0_req = 0;
        end
        check("hold_extra_ack_count", nack, 2);
        check("hold_extra_we_cycles", wes, 2);
        check("hold_extra_mem", mem[20], 32'h00000011);

        // ---------------- req dropped before ack still completes ----------------
        @(posedge CLK); #1;
        m1_req = 1; m1_we = 1; m1_addr = 32'd30; m1_wdata = 32'h00000077;
        nack = 0; a1 = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (m1_ack) begin nack++; if (a1 < 0) a1 = k; end
            @(posedge CLK); #1;
            if (k == 1) m1_req = 0;
        end
        check("early_drop_ack_cycle", a1, 3);
        check("early_drop_ack_count", nack, 1);
        check("early_drop_mem", mem[30], 32'h00000077);

        // ---------------- randomized traffic vs transaction-level model ----------------
        do_reset();
        for (int i = 0; i < LOC; i++) ref_mem[i] = mem[i];
        rr_m = 1'b0; exp_q.delete();
        iss0 = 0; iss1 = 0; ackc0 = 0; ackc1 = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin e = exp_q.pop_front(); was_busy = 1'b1; end
            else begin e = '0; was_busy = 1'b0; end
            got = sample();
            check("rand_cycle", got, e);
            if (e.ack0) rr_m = 1'b1;
            if (e.ack1) rr_m = 1'b0;
            if (!was_busy && (m0_req || m1_req)) begin
                w      = (m0_req && m1_req) ? rr_m : m1_req;
                t_we   = w ? m1_we    : m0_we;
                t_addr = w ? m1_addr  : m0_addr;
                t_wd   = w ? m1_wdata : m0_wdata;
                legal  = (t_addr < 32'(LOC));
                res    = (!t_we && legal) ? ref_mem[t_addr[7:0]] : 32'h0;
                if (t_we && legal) ref_mem[t_addr[7:0]] = t_wd;
                e = '0; e.busy = 1'b1; e.mem_we = t_we && legal;
                exp_q.push_back(e);
                e = '0; e.busy = 1'b1;
                if (w) begin e.ack1 = 1'b1; e.err1 = !legal; e.rd1 = res; end
                else   begin e.ack0 = 1'b1; e.err0 = !legal; e.rd0 = res; end
                exp_q.push_back(e);
            end
            drop0 = m0_ack; drop1 = m1_ack;
            @(posedge CLK); #1;
            if (drop0) begin
                m0_req = 1'b0; ackc0++;
            end else if (!m0_req && c < NCYC - 20 && $urandom_range(0, 2) == 0) begin
                m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1));
                m0_addr = rand_addr(); m0_wdata = $urandom; iss0++;
            end
            if (drop1) begin
                m1_req = 1'b0; ackc1++;
            end else if (!m1_req && c < NCYC - 20 && $urandom_range(0, 2) == 0) begin
                m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1));
                m1_addr = rand_addr(); m1_wdata = $urandom; iss1++;
            end
        end
        check("rand_m0_one_ack_per_req", ackc0, iss0);
        check("rand_m1_one_ack_per_req", ackc1, iss1);
        bad = 0;
        for (int i = 0; i < LOC; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("rand_mem_image", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
